// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter and its requesters.
package regfile_wb_arbiter_pkg;

    localparam int unsigned NUM_REQ    = 3;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned GRANT_ID_W = 3;

    localparam int unsigned WB_SRC_ALU = 0;
    localparam int unsigned WB_SRC_MDU = 1;
    localparam int unsigned WB_SRC_LSU = 2;

    // Next round-robin start index after idx, wrapping at n-1 -> 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: first valid request at or after ptr_i wins.
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_oh_c_o,
    output logic [IDX_W-1:0] gnt_idx_c_o,
    output logic             gnt_vld_c_o
);

    int unsigned cand;

    always_comb begin
        gnt_oh_c_o  = '0;
        gnt_idx_c_o = '0;
        gnt_vld_c_o = 1'b0;
        cand        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_vld_c_o && req_i[cand]) begin
                gnt_vld_c_o      = 1'b1;
                gnt_idx_c_o      = IDX_W'(cand);
                gnt_oh_c_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ result producers onto the single register-file write-back port
// through one registered output stage; writes to x0 are accepted but never issued.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ = regfile_wb_arbiter_pkg::NUM_REQ,
    parameter bit          RR_MODE = 1'b1,
    parameter int unsigned XLEN    = regfile_wb_arbiter_pkg::XLEN
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic [NUM_REQ-1:0]                                wb_req_valid_i,
    input  logic [regfile_wb_arbiter_pkg::REG_ADDR_W*NUM_REQ-1:0] wb_req_rd_i,
    input  logic [XLEN*NUM_REQ-1:0]                           wb_req_data_i,
    output logic [NUM_REQ-1:0]                                wb_req_ready_o,
    input  logic                                              hold_i,
    output logic                                              reg_write_wb_o,
    output logic [regfile_wb_arbiter_pkg::REG_ADDR_W-1:0]     reg_rd_wb_o,
    output logic [XLEN-1:0]                                   reg_data_rd_wb_o,
    output logic [regfile_wb_arbiter_pkg::GRANT_ID_W-1:0]     wb_grant_id_o,
    output logic                                              wb_busy_o
);
    import regfile_wb_arbiter_pkg::*;

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  write_q, write_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [GRANT_ID_W-1:0] gid_q, gid_d;

    logic [NUM_REQ-1:0]    req_eff;
    logic [IDX_W-1:0]      arb_ptr;
    logic [NUM_REQ-1:0]    gnt_oh;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_vld;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    // Reset and hold both mask every request so no handshake can complete.
    assign req_eff = (rst_i || hold_i) ? '0 : wb_req_valid_i;
    assign arb_ptr = RR_MODE ? rr_ptr_q : '0;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i       (req_eff),
        .ptr_i       (arb_ptr),
        .gnt_oh_c_o  (gnt_oh),
        .gnt_idx_c_o (gnt_idx),
        .gnt_vld_c_o (gnt_vld)
    );

    assign wb_req_ready_o = gnt_oh;
    assign wb_busy_o      = |(wb_req_valid_i & ~gnt_oh);

    // One-hot payload mux of the granted requester.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (gnt_oh[r]) begin
                sel_rd   = wb_req_rd_i[r*REG_ADDR_W +: REG_ADDR_W];
                sel_data = wb_req_data_i[r*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        write_d  = 1'b0;
        rd_d     = rd_q;
        data_d   = data_q;
        gid_d    = gid_q;
        if (gnt_vld) begin
            rr_ptr_d = IDX_W'(wrap_inc(32'(gnt_idx), NUM_REQ));
            write_d  = (sel_rd != '0);
            rd_d     = sel_rd;
            data_d   = sel_data;
            gid_d    = GRANT_ID_W'(gnt_idx);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            write_q  <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            gid_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            write_q  <= write_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
        end
    end

    assign reg_write_wb_o   = write_q;
    assign reg_rd_wb_o      = rd_q;
    assign reg_data_rd_wb_o = data_q;
    assign wb_grant_id_o    = gid_q;

endmodule
